// File: rtl/elev_pkg.sv
// Shared encodings for the elevator request servicer: FSM states and travel direction.
package elev_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MOVE_UP = 2'd1,
    MOVE_DN = 2'd2,
    DOOR    = 2'd3
  } state_t;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_t;

endpackage

// File: rtl/elev_timer.sv
// Loadable down-counter with a done flag. One instance is shared between
// floor-to-floor travel and door-open timing, since the two never overlap.
// done is high while the count sits at zero; en gates the decrement.
module elev_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         Reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] count;

  // Load has priority; otherwise count down to zero and hold there.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/elev_request_servicer.sv
// Elevator request servicer: latches call-button pulses into a pending vector,
// scans it SCAN-style and drives the car floor by floor, opening the door at
// each requested floor and pulsing served for that floor.
// Optional feature macro: DOOR_HOLD_EN adds a door_hold input that freezes the
// door timer while high; without it the door always closes after DOOR_CYCLES.
module elev_request_servicer #(
  parameter int FLOORS        = 8,
  parameter int FLOOR_W       = 3,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 6
) (
  input  logic               clk,
  input  logic               Reset,
`ifdef DOOR_HOLD_EN
  input  logic               door_hold,
`endif
  input  logic [FLOORS-1:0]  req_in,
  output logic [FLOORS-1:0]  pending,
  output logic [FLOOR_W-1:0] cur_floor,
  output logic               moving_up,
  output logic               moving_dn,
  output logic               door_open,
  output logic [FLOORS-1:0]  served
);

  import elev_pkg::*;

  localparam int MAX_CYC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] TRAVEL_LOAD = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DOOR_LOAD   = CNT_W'(DOOR_CYCLES - 1);

  state_t             state, state_next;
  dir_t               dir, dir_next;
  logic [FLOOR_W-1:0] floor_next;
  logic [FLOOR_W-1:0] arrive_floor;
  logic [FLOORS-1:0]  pend_eff;
  logic [FLOORS-1:0]  hit_vec, above_mask, below_mask;
  logic               here, any_above, any_below, door_req;
  logic               tmr_load, tmr_en, tmr_done;
  logic [CNT_W-1:0]   tmr_val;
  logic               hold;

`ifdef DOOR_HOLD_EN
  assign hold = door_hold;
`else
  assign hold = 1'b0;
`endif

  // Requests seen this cycle count as pending for the scan decisions.
  assign pend_eff = pending | req_in;

  // Floor the decision refers to: the next floor on an arrival cycle, otherwise the current one.
  always_comb begin
    arrive_floor = cur_floor;
    case (state)
      MOVE_UP: arrive_floor = cur_floor + FLOOR_W'(1);
      MOVE_DN: arrive_floor = cur_floor - FLOOR_W'(1);
      default: arrive_floor = cur_floor;
    endcase
  end

  // Per-floor position masks relative to the decision floor.
  generate
    for (genvar gi = 0; gi < FLOORS; gi++) begin : g_scan
      assign hit_vec[gi]    = (arrive_floor == FLOOR_W'(gi));
      assign above_mask[gi] = (FLOOR_W'(gi) > arrive_floor);
      assign below_mask[gi] = (FLOOR_W'(gi) < arrive_floor);
    end
  endgenerate

  assign here      = |(pend_eff & hit_vec);
  assign any_above = |(pend_eff & above_mask);
  assign any_below = |(pend_eff & below_mask);
  assign door_req  = |(req_in & hit_vec);

  assign moving_up = (state == MOVE_UP);
  assign moving_dn = (state == MOVE_DN);
  assign door_open = (state == DOOR);
  assign tmr_en    = moving_up || moving_dn || (door_open && !hold);

  elev_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .Reset    (Reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .done     (tmr_done)
  );

  // State, direction, floor and pending registers; served clears its bit in the same cycle.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      dir       <= DIR_UP;
      cur_floor <= '0;
      pending   <= '0;
    end else begin
      state     <= state_next;
      dir       <= dir_next;
      cur_floor <= floor_next;
      pending   <= (pending | req_in) & ~served;
    end
  end

  // Next-state, timer control and served pulse.
  always_comb begin
    state_next = state;
    dir_next   = dir;
    floor_next = cur_floor;
    served     = '0;
    tmr_load   = 1'b0;
    tmr_val    = TRAVEL_LOAD;
    case (state)
      IDLE: begin
        if (here) begin
          state_next = DOOR;
          served     = hit_vec;
          tmr_load   = 1'b1;
          tmr_val    = DOOR_LOAD;
        end else if (any_above && ((dir == DIR_UP) || !any_below)) begin
          state_next = MOVE_UP;
          dir_next   = DIR_UP;
          tmr_load   = 1'b1;
        end else if (any_below) begin
          state_next = MOVE_DN;
          dir_next   = DIR_DN;
          tmr_load   = 1'b1;
        end
      end
      MOVE_UP, MOVE_DN: begin
        if (tmr_done) begin
          floor_next = arrive_floor;
          if (here) begin
            state_next = DOOR;
            served     = hit_vec;
            tmr_load   = 1'b1;
            tmr_val    = DOOR_LOAD;
          end else if ((state == MOVE_UP) ? any_above : any_below) begin
            tmr_load = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      DOOR: begin
        if (door_req) begin
          served   = hit_vec;
          tmr_load = 1'b1;
          tmr_val  = DOOR_LOAD;
        end else if (tmr_done && !hold) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
